ibpl_in_debounce: RTL and testbench

//  Per-channel input conditioning stage for interbackplane input cardlets.
//  - Sits between the raw backplane input pins and the cardlet's diob_in.
//  - Synchronises each pin into the clk domain and rejects bounce/glitches.
//  - Produces a per-channel activity flag, stretched so it is visible on the front-panel LEDs.

---
 rtl/ibpl_in_debounce.sv | 107 ++++++++++
 tb/tb_ibpl_in_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ibpl_in_debounce.sv
// rtl/ibpl_in_debounce.sv - per-channel input synchroniser, debouncer and activity stretcher (optional edge strobe: IBPL_IN_DEBOUNCE_EDGE_EN)
module ibpl_in_debounce #(
    parameter int CHANNELS       = 6,
    parameter int DEB_CYCLES     = 1250,
    parameter int DEB_W          = 16,
    parameter int STRETCH_CYCLES = 6250000,
    parameter int STRETCH_W      = 23
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [CHANNELS-1:0] pin_in,
    input  logic [CHANNELS-1:0] input_enable,
    output logic [CHANNELS-1:0] diob_in,
    output logic [CHANNELS-1:0] input_act,
    output logic [CHANNELS-1:0] edge_rise
);

    localparam logic [DEB_W-1:0]     DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STRETCH_W-1:0] ST_LOAD  = STRETCH_W'(STRETCH_CYCLES);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;

    // Two-flop synchroniser; keeps running even while a channel is disabled
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DEB_W-1:0]     deb_cnt;
        logic [DEB_W-1:0]     deb_cnt_nxt;
        logic [STRETCH_W-1:0] st_cnt;
        logic [STRETCH_W-1:0] st_cnt_nxt;
        logic                 diob_q;
        logic                 diob_nxt;
        logic                 act_q;
        logic                 accept;

        // Debounce and stretch next-state; a disabled channel is forced quiet without counting as activity
        always_comb begin
            accept      = 1'b0;
            diob_nxt    = diob_q;
            deb_cnt_nxt = '0;
            st_cnt_nxt  = st_cnt;
            if (!input_enable[i]) begin
                diob_nxt   = 1'b0;
                st_cnt_nxt = '0;
            end else begin
                if (s2[i] == diob_q) begin
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    accept   = 1'b1;
                    diob_nxt = s2[i];
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
                if (accept) begin
                    st_cnt_nxt = ST_LOAD;
                end else if (st_cnt != '0) begin
                    st_cnt_nxt = st_cnt - 1'b1;
                end
            end
        end

        // Channel state registers; the activity flag is registered from the counter's next value
        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                deb_cnt <= '0;
                st_cnt  <= '0;
                diob_q  <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                deb_cnt <= deb_cnt_nxt;
                st_cnt  <= st_cnt_nxt;
                diob_q  <= diob_nxt;
                act_q   <= (st_cnt_nxt != '0);
            end
        end

        assign diob_in[i]   = diob_q;
        assign input_act[i] = act_q;

`ifdef IBPL_IN_DEBOUNCE_EDGE_EN
        logic edge_q;

        // One-cycle strobe coincident with an accepted 0->1 change
        always_ff @(posedge clk or negedge nReset) begin
            if (!nReset) begin
                edge_q <= 1'b0;
            end else begin
                edge_q <= accept & s2[i];
            end
        end

        assign edge_rise[i] = edge_q;
`else
        assign edge_rise[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ibpl_in_debounce.sv
// tb/tb_ibpl_in_debounce.sv - scoreboard bench for ibpl_in_debounce against a time-window reference model
module tb_ibpl_in_debounce;

    localparam int CH  = 6;
    localparam int DEB = 4;
    localparam int STR = 8;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic [CH-1:0] pin_in = '0;
    logic [CH-1:0] input_enable = '0;
    logic [CH-1:0] diob_in;
    logic [CH-1:0] input_act;
    logic [CH-1:0] edge_rise;

    ibpl_in_debounce #(
        .CHANNELS      (CH),
        .DEB_CYCLES    (DEB),
        .DEB_W         (4),
        .STRETCH_CYCLES(STR),
        .STRETCH_W     (4)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .pin_in      (pin_in),
        .input_enable(input_enable),
        .diob_in     (diob_in),
        .input_act   (input_act),
        .edge_rise   (edge_rise)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] d;
        logic [CH-1:0] a;
        logic [CH-1:0] e;
    } exp_t;

    exp_t          sb[$];
    logic [CH-1:0] pin_hist[$];
    logic [CH-1:0] en_hist[$];
    int            level[CH];
    int            last_acc[CH];
    int            last_dis[CH];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            stim_done = 1'b0;

    // Reference model: a level is accepted once the delayed pin has disagreed with the
    // current output on DEB consecutive enabled edges; activity lasts STR edges from the
    // latest acceptance unless a disable intervenes.
    always @(posedge clk) begin
        exp_t x;
        int   t;
        bit   acc;
        x = '0;
        if (!nReset) begin
            pin_hist.delete();
            en_hist.delete();
            for (int c = 0; c < CH; c++) begin
                level[c]    = 0;
                last_acc[c] = -1;
                last_dis[c] = -1;
            end
        end else begin
            t = pin_hist.size();
            pin_hist.push_back(pin_in);
            en_hist.push_back(input_enable);
            for (int c = 0; c < CH; c++) begin
                if (!input_enable[c]) begin
                    level[c]    = 0;
                    last_dis[c] = t;
                end else begin
                    acc = 1'b1;
                    for (int k = 0; k < DEB; k++) begin
                        int  idx;
                        int  pv;
                        logic [CH-1:0] ev;
                        logic [CH-1:0] pw;
                        idx = t - k;
                        if (idx < 0) begin
                            acc = 1'b0;
                        end else begin
                            ev = en_hist[idx];
                            if (!ev[c]) acc = 1'b0;
                            if (idx - 2 < 0) begin
                                pv = 0;
                            end else begin
                                pw = pin_hist[idx - 2];
                                pv = int'(pw[c]);
                            end
                            if (pv == level[c]) acc = 1'b0;
                        end
                    end
                    if (acc) begin
                        level[c]    = 1 - level[c];
                        last_acc[c] = t;
`ifdef IBPL_IN_DEBOUNCE_EDGE_EN
                        x.e[c] = (level[c] == 1);
`endif
                    end
                end
                x.d[c] = (level[c] == 1);
                x.a[c] = (last_acc[c] > last_dis[c]) && (t - last_acc[c] < STR);
            end
        end
        sb.push_back(x);
    end

    // Monitor: every negedge the DUT outputs are compared with the oldest expectation
    always @(negedge clk) begin
        exp_t x;
        if (!stim_done || sb.size() != 0) begin
            cyc++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty cyc=%0d got=none exp=entry", cyc);
            end else begin
                x = sb.pop_front();
                if (diob_in !== x.d) begin
                    bad++;
                    $display("FAIL diob_in cyc=%0d got=%h exp=%h", cyc, diob_in, x.d);
                end
                total++;
                if (input_act !== x.a) begin
                    bad++;
                    $display("FAIL input_act cyc=%0d got=%h exp=%h", cyc, input_act, x.a);
                end
                total++;
                if (edge_rise !== x.e) begin
                    bad++;
                    $display("FAIL edge_rise cyc=%0d got=%h exp=%h", cyc, edge_rise, x.e);
                end
            end
        end
    end

    task automatic drive(input logic [CH-1:0] p, input logic [CH-1:0] e, input int n);
        pin_in       = p;
        input_enable = e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asynchronous reset pulse taken between monitor sampling and the next edge
    task automatic reset_pulse(input logic [CH-1:0] p, input logic [CH-1:0] e);
        @(negedge clk);
        #1;
        nReset = 1'b0;
        #1;
        total++;
        if ({diob_in, input_act, edge_rise} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", {diob_in, input_act, edge_rise});
        end
        @(posedge clk);
        #2;
        drive(p, e, 2);
        nReset = 1'b1;
    endtask

    initial begin
        logic [CH-1:0] p;
        logic [CH-1:0] e;
        drive('0, 6'h3F, 3);
        nReset = 1'b1;
        drive('0, 6'h3F, 20);
        drive(6'h01, 6'h3F, 12);
        drive(6'h03, 6'h3F, 3);
        drive(6'h01, 6'h3F, 10);
        drive(6'h05, 6'h3F, 5);
        drive(6'h01, 6'h3F, 15);
        drive(6'h09, 6'h3F, 8);
        drive(6'h09, 6'h37, 3);
        drive(6'h09, 6'h3F, 12);
        drive(6'h19, 6'h3F, 4);
        reset_pulse(6'h19, 6'h3F);
        drive(6'h19, 6'h3F, 12);
        p = 6'h19;
        e = 6'h3F;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) p[c] = ~p[c];
                e[c] = ($urandom_range(0, 24) != 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse(p, e);
            end
            drive(p, e, 1);
        end
        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
